// File: rtl/key_repeat_gen.sv
// key_repeat_gen: turns a held button level into single-cycle strobes.
// One strobe on press, one after DELAY ce ticks, then one every PERIOD ticks
// while the button stays down. Timing is counted in ce ticks.
module key_repeat_gen #(
  parameter int unsigned DELAY  = 500,
  parameter int unsigned PERIOD = 100,
  parameter int unsigned CW     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ce,
  input  logic in,
  output logic out,
  output logic rpt
);

  localparam logic [CW-1:0] DELAY_LAST  = CW'(DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          in_q;
  logic          out_nxt;

  // State, tick counter, input history and strobe register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      in_q  <= 1'b0;
      out   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      in_q  <= in;
      out   <= out_nxt;
    end
  end

  // Next-state, counter and strobe decode; release always wins over a terminal tick
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (in && !in_q) begin
          out_nxt   = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (!in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (ce) begin
          if (cnt == DELAY_LAST) begin
            out_nxt   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = REPEAT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      REPEAT: begin
        if (!in) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (ce) begin
          if (cnt == PERIOD_LAST) begin
            out_nxt = 1'b1;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Repeat-phase indicator decoded from the state register
  assign rpt = (state == REPEAT);

endmodule
